hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Issue and hazard controller for the RV32 in-order pipeline, placed between decode and execute. It keeps a per-register scoreboard of in-flight long-latency writes (load, MUL, DIV) and stalls decode on RAW and WAW conflicts. It also blocks a second divide while the unpipelined divider is busy, serializes SYSTEM instructions, and produces the IF/ID flush on an EX-stage redirect. ALU results are fully forwarded and never stall.

Parameters:
NUM_REGS, 32, architectural register count (index 0 is x0, hardwired zero)
DIV_LAT, 33, cycles the divider stays busy after a DIV issues (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset. One clock; reset is asynchronous and active-high.
id_valid_i  in  1  valid instruction present in ID
id_rs1_i  in  5  source register 1
id_rs2_i  in  5  source register 2
id_rs1_used_i  in  1  rs1 is read by this instruction
id_rs2_used_i  in  1  rs2 is read by this instruction
id_rd_i  in  5  destination register
id_rd_we_i  in  1  instruction writes rd
id_fu_i  in  3  unit select: 0 ALU, 1 LOAD, 2 MUL, 3 DIV, 4 BRANCH/JUMP, 5 SYSTEM; 6-7 treated as ALU
ex_redirect_i  in  1  branch/jump resolved taken or mispredicted in EX
wb_valid_i  in  1  long-latency result written back this cycle
wb_rd_i  in  5  register written back
hazard_stall_o  out  1  hold IF/ID; inject a bubble into EX
issue_o  out  1  instruction in ID advances to EX this cycle
control_hazard_o  out  2  [0] flush IF, [1] flush ID
div_busy_o  out  1  divider occupied
pending_o  out  NUM_REGS  scoreboard snapshot (debug and verification)

Behaviour:
- Reset (async, any cycle, including mid-divide):
  - pending <= 0, div_cnt <= 0.
  - All outputs are 0 while rst_i is high and id_valid_i = 0.
- Effective pending this cycle: pend_eff = pending & ~(wb_valid_i ? onehot(wb_rd_i) : 0).
  - The register file is write-through, so a same-cycle writeback resolves the hazard.
- Stall conditions. hazard_stall_o = id_valid_i & ~ex_redirect_i & (any of):
  - RAW: id_rs1_used_i & rs1 != 0 & pend_eff[rs1], or the same check for rs2.
  - WAW: id_rd_we_i & rd != 0 & pend_eff[rd].
  - Structural: id_fu_i == DIV & div_cnt != 0.
  - Serialize: id_fu_i == SYSTEM & (pend_eff != 0 | div_cnt != 0).
- issue_o = id_valid_i & ~hazard_stall_o & ~ex_redirect_i. All outputs above are combinational.
- Redirect:
  - control_hazard_o = {ex_redirect_i, ex_redirect_i} in the same cycle.
  - The ID instruction is squashed: no issue, no stall, no scoreboard set.
  - Older in-flight entries are kept.
- Scoreboard update on clock edge:
  - Clear: wb_valid_i clears pending[wb_rd_i].
  - Set: issue_o & id_rd_we_i & rd != 0 & id_fu_i in {LOAD, MUL, DIV} sets pending[rd].
  - If set and clear hit the same register in one cycle, set wins.
  - pending[0] is never set.
  - wb_valid_i to a non-pending register is ignored.
- Divider counter:
  - issue_o & id_fu_i == DIV loads div_cnt <= DIV_LAT-1.
  - Otherwise div_cnt decrements while nonzero and saturates at 0.
  - div_busy_o = (div_cnt != 0).
  - A DIV's completion is signalled to the scoreboard only through wb_valid_i; the counter guards only the structural hazard.
- BRANCH/JUMP and ALU never set pending.
- Latency from writeback to the dependent instruction issuing: 0 cycles (same cycle).

Test Plan:
- Load-use: LOAD x5 issues; next cycle ADD reads x5 with no wb -> hazard_stall_o=1 and issue_o=0 each cycle. wb_valid_i=1 with wb_rd_i=5 -> same cycle hazard_stall_o=0, issue_o=1, and pending_o[5] reads 0 the next cycle.
- Divider structural hazard (DIV_LAT=33): DIV x3 issues at cycle t; a DIV x4 in ID stalls for cycles t+1..t+32 and issues at t+33. div_busy_o=1 over exactly t+1..t+32.
- x0 and redirect:
  - LOAD to x0 -> pending_o stays 0; a following reader of x0 is not stalled.
  - ex_redirect_i=1 while ID is stalled on x7 -> control_hazard_o=2'b11, hazard_stall_o=0, issue_o=0; pending[7] unchanged.
- Same-cycle set/clear: wb_valid_i for x9 and MUL x9 issuing in the same cycle -> pending_o[9]=1 after the edge.
- SYSTEM serialization: pending={x2}, SYSTEM in ID -> stall until wb of x2, then issue the same cycle. With div_cnt=5 and pending=0 -> stall for 5 cycles.
- Reset mid-divide: assert rst_i with div_cnt=20 and pending={x1,x6} -> immediately div_busy_o=0 and pending_o=0; after release, a DIV issues without stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Issue and hazard controller sitting between decode (ID) and execute (EX)
// of the RV32 in-order pipeline.
//
// It keeps a per-register scoreboard of long-latency writes in flight
// (LOAD, MUL, DIV) and stalls ID on RAW / WAW conflicts against it. It also:
// - blocks a second DIV while the unpipelined divider is busy;
// - holds SYSTEM instructions until the machine is quiet;
// - produces the IF/ID flush on an EX redirect.
// ALU results are fully forwarded, so ALU producers never enter the
// scoreboard.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   id_valid_i          instruction present in ID
//   id_rs1_i/_used_i    source 1 index and read-enable
//   id_rs2_i/_used_i    source 2 index and read-enable
//   id_rd_i/id_rd_we_i  destination index and write-enable
//   id_fu_i             unit: 0 ALU, 1 LOAD, 2 MUL, 3 DIV, 4 BR/JMP,
//                       5 SYSTEM, 6-7 ALU
//   ex_redirect_i       taken/mispredicted control transfer resolved in EX
//   wb_valid_i/wb_rd_i  long-latency writeback this cycle
//   hazard_stall_o      hold IF/ID, bubble into EX
//   issue_o             ID instruction moves to EX this cycle
//   control_hazard_o    [0] flush IF, [1] flush ID
//   div_busy_o          divider occupied
//   pending_o           scoreboard snapshot
//
// Handshake: id_valid_i / issue_o behave as a valid/ready pair. The ID
// instruction transfers into EX on a cycle where both are high. While
// id_valid_i is high and issue_o is low, ID must hold the same instruction.
// The one exception is a redirect, which squashes it: the flush outputs
// are raised and nothing transfers.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int NUM_REGS = 32,
  parameter int DIV_LAT  = 33
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                id_valid_i,
  input  logic [4:0]          id_rs1_i,
  input  logic [4:0]          id_rs2_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic [4:0]          id_rd_i,
  input  logic                id_rd_we_i,
  input  logic [2:0]          id_fu_i,
  input  logic                ex_redirect_i,
  input  logic                wb_valid_i,
  input  logic [4:0]          wb_rd_i,
  output logic                hazard_stall_o,
  output logic                issue_o,
  output logic [1:0]          control_hazard_o,
  output logic                div_busy_o,
  output logic [NUM_REGS-1:0] pending_o
);

  // Unit select encodings
  localparam logic [2:0] FU_ALU  = 3'd0;
  localparam logic [2:0] FU_LOAD = 3'd1;
  localparam logic [2:0] FU_MUL  = 3'd2;
  localparam logic [2:0] FU_DIV  = 3'd3;
  localparam logic [2:0] FU_BRJ  = 3'd4;
  localparam logic [2:0] FU_SYS  = 3'd5;

  localparam int CNT_W = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  // One-hot of a register index.
  // Indices beyond NUM_REGS map to zero, so a narrow register file never
  // sees an out-of-range bit select.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [4:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(idx) == i) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  // State
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;

  // Decode of the unit select
  logic fu_long;   // result arrives later through wb_valid_i
  logic fu_div;
  logic fu_sys;

  always_comb begin
    fu_long = 1'b0;
    fu_div  = 1'b0;
    fu_sys  = 1'b0;
    case (id_fu_i)
      FU_LOAD, FU_MUL: fu_long = 1'b1;
      FU_DIV: begin
        fu_long = 1'b1;
        fu_div  = 1'b1;
      end
      FU_SYS:         fu_sys = 1'b1;
      FU_ALU, FU_BRJ: ;  // forwarded, never tracked
      default:        ;  // 6-7 behave as ALU
    endcase
  end

  // Effective scoreboard.
  // The register file is write-through, so a writeback landing this cycle
  // already satisfies a reader in ID.
  logic [NUM_REGS-1:0] wb_oh;
  logic [NUM_REGS-1:0] pend_eff;
  logic [NUM_REGS-1:0] rs1_oh, rs2_oh, rd_oh;

  always_comb begin
    wb_oh    = wb_valid_i ? reg_onehot(wb_rd_i) : '0;
    pend_eff = pending_q & ~wb_oh;
    rs1_oh   = reg_onehot(id_rs1_i);
    rs2_oh   = reg_onehot(id_rs2_i);
    rd_oh    = reg_onehot(id_rd_i);
  end

  // Hazard terms
  logic div_busy;
  logic raw_hz, waw_hz, struct_hz, sys_hz;
  logic rs1_nz, rs2_nz, rd_nz;

  always_comb begin
    div_busy  = (div_cnt_q != '0);
    rs1_nz    = (id_rs1_i != 5'd0);
    rs2_nz    = (id_rs2_i != 5'd0);
    rd_nz     = (id_rd_i  != 5'd0);
    raw_hz    = (id_rs1_used_i & rs1_nz & (|(pend_eff & rs1_oh))) |
                (id_rs2_used_i & rs2_nz & (|(pend_eff & rs2_oh)));
    waw_hz    = id_rd_we_i & rd_nz & (|(pend_eff & rd_oh));
    struct_hz = fu_div & div_busy;
    sys_hz    = fu_sys & ((|pend_eff) | div_busy);
  end

  // Outputs.
  // A redirect squashes ID, so it also suppresses the stall: the flush
  // replaces the instruction rather than holding it.
  always_comb begin
    hazard_stall_o   = id_valid_i & ~ex_redirect_i &
                       (raw_hz | waw_hz | struct_hz | sys_hz);
    issue_o          = id_valid_i & ~hazard_stall_o & ~ex_redirect_i;
    control_hazard_o = {ex_redirect_i, ex_redirect_i};
    div_busy_o       = div_busy;
    pending_o        = pending_q;
  end

  // Scoreboard next state.
  // The clear is applied first and the set after it, so a same-cycle set
  // of the same register wins. Bit 0 is masked so x0 can never be tracked.
  logic sb_set;

  always_comb begin
    sb_set    = issue_o & id_rd_we_i & rd_nz & fu_long;
    pending_d = pending_q & ~wb_oh;
    if (sb_set) pending_d = pending_d | rd_oh;
    pending_d[0] = 1'b0;
  end

  // Divider occupancy counter.
  // It only guards the structural hazard. The DIV result itself is
  // tracked by the scoreboard and retired by wb_valid_i.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (issue_o & fu_div) begin
      div_cnt_d = DIV_LOAD;
    end else if (div_busy) begin
      div_cnt_d = div_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
      div_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl (NUM_REGS=32, DIV_LAT=33).
//
// Timing:
// - Inputs change 1 time unit after the rising edge.
// - Combinational outputs are sampled 1 time unit after that.
// - Registered state is sampled right after the following edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [2:0] ALU  = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] MUL  = 3'd2;
  localparam logic [2:0] DIV  = 3'd3;
  localparam logic [2:0] SYS  = 3'd5;
  localparam logic [2:0] ALU6 = 3'd6;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid, rs1_used, rs2_used, rd_we, redirect, wb_valid;
  logic [4:0]  rs1, rs2, rd, wb_rd;
  logic [2:0]  fu;
  logic        stall, issue, div_busy;
  logic [1:0]  ch;
  logic [31:0] pending;

  hazard_ctrl #(.NUM_REGS(32), .DIV_LAT(33)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .id_valid_i       (id_valid),
    .id_rs1_i         (rs1),
    .id_rs2_i         (rs2),
    .id_rs1_used_i    (rs1_used),
    .id_rs2_used_i    (rs2_used),
    .id_rd_i          (rd),
    .id_rd_we_i       (rd_we),
    .id_fu_i          (fu),
    .ex_redirect_i    (redirect),
    .wb_valid_i       (wb_valid),
    .wb_rd_i          (wb_rd),
    .hazard_stall_o   (stall),
    .issue_o          (issue),
    .control_hazard_o (ch),
    .div_busy_o       (div_busy),
    .pending_o        (pending)
  );

  // Scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic set_id(input logic [2:0] f, input logic [4:0] s1,
                        input logic u1, input logic [4:0] s2, input logic u2,
                        input logic [4:0] d, input logic we);
    id_valid = 1'b1;
    fu = f;
    rs1 = s1;
    rs1_used = u1;
    rs2 = s2;
    rs2_used = u2;
    rd = d;
    rd_we = we;
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    fu = ALU;
    rs1 = 5'd0;
    rs1_used = 1'b0;
    rs2 = 5'd0;
    rs2_used = 1'b0;
    rd = 5'd0;
    rd_we = 1'b0;
    #1;
  endtask

  task automatic wb(input logic v, input logic [4:0] r);
    wb_valid = v;
    wb_rd = r;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks for one combinational cycle
  task automatic chk_sti(input string tag, input logic s, input logic i);
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    check({tag, ".issue"}, {31'd0, issue}, {31'd0, i});
  endtask

  initial begin
    redirect = 1'b0;
    wb_valid = 1'b0;
    wb_rd = 5'd0;
    idle();

    // Reset state
    check("rst.pending", pending, 32'h0);
    check("rst.div_busy", {31'd0, div_busy}, 32'd0);
    check("rst.ch", {30'd0, ch}, 32'd0);
    chk_sti("rst", 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // Load-use: LOAD x5, then ADD reads x5
    set_id(LOAD, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1);
    chk_sti("lu.load", 1'b0, 1'b1);
    tick();
    check("lu.pend5", pending, 32'h0000_0020);
    set_id(ALU, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1);
    chk_sti("lu.c1", 1'b1, 1'b0);
    tick();
    chk_sti("lu.c2", 1'b1, 1'b0);
    check("lu.hold", pending, 32'h0000_0020);
    wb(1'b1, 5'd5);
    chk_sti("lu.wb", 1'b0, 1'b1);
    tick();
    wb(1'b0, 5'd0);
    idle();
    check("lu.clr", pending, 32'h0);

    // x0 destination and ALU-class units are never tracked
    set_id(LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
    tick();
    check("x0.pend", pending, 32'h0);
    set_id(ALU6, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1);
    chk_sti("x0.read", 1'b0, 1'b1);
    tick();
    idle();
    check("alu6.pend", pending, 32'h0);

    // Redirect while stalled on x7
    set_id(LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
    tick();
    check("rd.pend7", pending, 32'h0000_0080);
    set_id(ALU, 5'd0, 1'b0, 5'd7, 1'b1, 5'd10, 1'b1);
    chk_sti("rd.pre", 1'b1, 1'b0);
    check("rd.ch0", {30'd0, ch}, 32'd0);
    redirect = 1'b1;
    #1;
    check("rd.ch", {30'd0, ch}, 32'd3);
    chk_sti("rd.sq", 1'b0, 1'b0);
    tick();
    redirect = 1'b0;
    idle();
    check("rd.keep7", pending, 32'h0000_0080);

    // Same-cycle set/clear on x9; WAW is resolved by the same-cycle wb
    set_id(LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    tick();
    check("sc.pend", pending, 32'h0000_0280);
    set_id(MUL, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1);
    chk_sti("sc.waw", 1'b1, 1'b0);
    wb(1'b1, 5'd9);
    chk_sti("sc.mul", 1'b0, 1'b1);
    tick();
    idle();
    check("sc.setwin", pending, 32'h0000_0280);
    tick();  // wb x9 still asserted, no issue
    check("sc.clr9", pending, 32'h0000_0080);
    wb(1'b1, 5'd7);
    tick();
    wb(1'b1, 5'd20);  // writeback to a non-pending register is ignored
    tick();
    wb(1'b0, 5'd0);
    check("sc.empty", pending, 32'h0);

    // SYSTEM waits for the pending x2
    set_id(LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1);
    tick();
    set_id(SYS, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    chk_sti("sys.c1", 1'b1, 1'b0);
    tick();
    chk_sti("sys.c2", 1'b1, 1'b0);
    wb(1'b1, 5'd2);
    chk_sti("sys.wb", 1'b0, 1'b1);
    tick();
    wb(1'b0, 5'd0);
    idle();
    check("sys.pend", pending, 32'h0);

    // Divider structural hazard: DIV x3 issues at cycle t
    set_id(DIV, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
    chk_sti("div.t", 1'b0, 1'b1);
    check("div.t.busy", {31'd0, div_busy}, 32'd0);
    tick();
    set_id(DIV, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
    for (int c = 1; c <= 32; c++) begin
      chk_sti($sformatf("div.t%0d", c), 1'b1, 1'b0);
      check($sformatf("div.busy%0d", c), {31'd0, div_busy}, 32'd1);
      tick();
    end
    check("div.t33.busy", {31'd0, div_busy}, 32'd0);
    chk_sti("div.t33", 1'b0, 1'b1);
    tick();
    idle();
    check("div.pend", pending, 32'h0000_0018);
    // Divider count is now 32; retire both results, run down to 5
    wb(1'b1, 5'd3);
    tick();
    wb(1'b1, 5'd4);
    tick();
    wb(1'b0, 5'd0);
    check("div.empty", pending, 32'h0);
    for (int c = 0; c < 25; c++) tick();
    set_id(SYS, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk_sti($sformatf("sysdiv.c%0d", c), 1'b1, 1'b0);
      tick();
    end
    chk_sti("sysdiv.go", 1'b0, 1'b1);
    check("sysdiv.busy", {31'd0, div_busy}, 32'd0);
    tick();
    idle();

    // Reset mid-divide
    set_id(DIV, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
    tick();
    set_id(LOAD, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
    tick();
    idle();
    for (int c = 0; c < 11; c++) tick();  // count 31 -> 20
    check("mr.busy", {31'd0, div_busy}, 32'd1);
    check("mr.pend", pending, 32'h0000_0042);
    #2;
    rst = 1'b1;
    #1;
    check("mr.rst.busy", {31'd0, div_busy}, 32'd0);
    check("mr.rst.pend", pending, 32'h0);
    chk_sti("mr.rst", 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    set_id(DIV, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1);
    chk_sti("mr.div", 1'b0, 1'b1);
    tick();
    idle();
    check("mr.busy2", {31'd0, div_busy}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
